// File: rtl/uart_defs.sv
// Shared UART receive-path definitions: oversampling ratio, frame layout and sampler states.
package uart_defs;

    localparam int unsigned UART_OSR      = 16;
    localparam int unsigned UART_STOP_IDX = 10;

    typedef enum logic [1:0] {
        SMP_IDLE  = 2'd0,
        SMP_START = 2'd1,
        SMP_BITS  = 2'd2
    } SamplerState_t;

    // Two-of-three majority of the mid-bit samples
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample prescaler: one registered tick every max(div_i,1) clk; restart re-phases it to a start edge.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             os_tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_c;

    // A divisor of 0 behaves like 1 (tick every cycle)
    assign last_c = (div_i == '0) ? '0 : div_i - DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            os_tick_o <= 1'b0;
        end else if (!enable_i || restart_i) begin
            cnt_q     <= '0;
            os_tick_o <= 1'b0;
        end else if (cnt_q >= last_c) begin
            cnt_q     <= '0;
            os_tick_o <= 1'b1;
        end else begin
            cnt_q     <= cnt_q + DIV_W'(1);
            os_tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronise rx, oversample, qualify start, majority-vote each bit
// and hand uart_rx one clean bit plus one tck rising edge per bit period.
module uart_rx_sampler
    import uart_defs::*;
#(
    parameter int unsigned OSR   = UART_OSR,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             rx_o,
    output logic             tck_o,
    output logic             busy_o,
    output logic             false_start_o,
    output logic             noise_o,
    output logic             break_o
);

    localparam int unsigned OS_W  = $clog2(OSR);
    localparam int unsigned BIT_W = 4;
    localparam logic [OS_W-1:0]  OS_S7    = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  OS_S8    = OS_W'(OSR / 2);
    localparam logic [OS_W-1:0]  OS_S9    = OS_W'(OSR / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OSR - 1);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(UART_STOP_IDX);

    SamplerState_t state_q, state_d;

    logic rx_meta, rx_s;
    logic os_tick;

    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             s7_q, s7_d, s8_q, s8_d;
    logic             all_zero_q, all_zero_d;
    logic             tck_arm_q, tck_arm_d;
    logic             rx_d, tck_d, fs_d, noise_d, break_d;

    logic [2:0] votes_c;
    logic       vote_c, disagree_c, start_det_c, commit_c;

    // Two-flop synchroniser, idle-high through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .restart_i (start_det_c),
        .div_i     (baud_div_i),
        .os_tick_o (os_tick)
    );

    assign votes_c    = {s7_q, s8_q, rx_s};
    assign vote_c     = maj3(votes_c);
    assign disagree_c = (|votes_c) && !(&votes_c);
    // Hold off detection for the cycle a stop-bit tck edge is still being launched
    assign start_det_c = enable_i && os_tick && !rx_s && !tck_arm_q && (state_q == SMP_IDLE);
    assign commit_c    = os_tick && (os_cnt_q == OS_S9) && (state_q != SMP_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SMP_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = SMP_IDLE;
        end else begin
            case (state_q)
                SMP_IDLE:  if (start_det_c) state_d = SMP_START;
                SMP_START: if (commit_c)    state_d = vote_c ? SMP_IDLE : SMP_BITS;
                SMP_BITS:  if (commit_c && (bit_cnt_q == BIT_STOP)) state_d = SMP_IDLE;
                default:   state_d = SMP_IDLE;
            endcase
        end
    end

    always_comb begin
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        all_zero_d = all_zero_q;
        tck_arm_d  = 1'b0;
        rx_d       = rx_o;
        tck_d      = tck_o;
        fs_d       = 1'b0;
        noise_d    = 1'b0;
        break_d    = 1'b0;

        if (!enable_i) begin
            os_cnt_d   = '0;
            bit_cnt_d  = '0;
            all_zero_d = 1'b0;
            rx_d       = 1'b1;
            tck_d      = 1'b0;
        end else begin
            // tck rises one clk after the commit that moved rx_o
            if (tck_arm_q) tck_d = 1'b1;
            if (os_tick) begin
                os_cnt_d = os_cnt_q + OS_W'(1);
                if (os_cnt_q == OS_LAST) begin
                    tck_d = 1'b0;
                    if (state_q == SMP_IDLE) rx_d = 1'b1;
                end
                if (os_cnt_q == OS_S7) s7_d = rx_s;
                if (os_cnt_q == OS_S8) s8_d = rx_s;

                case (state_q)
                    SMP_IDLE: begin
                        if (start_det_c) begin
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                            rx_d      = 1'b1;
                            tck_d     = 1'b0;
                        end
                    end
                    SMP_START: begin
                        if (commit_c) begin
                            noise_d = disagree_c;
                            if (vote_c) begin
                                fs_d = 1'b1;
                            end else begin
                                rx_d       = 1'b0;
                                tck_arm_d  = 1'b1;
                                bit_cnt_d  = BIT_W'(1);
                                all_zero_d = 1'b1;
                            end
                        end
                    end
                    SMP_BITS: begin
                        if (commit_c) begin
                            noise_d    = disagree_c;
                            rx_d       = vote_c;
                            tck_arm_d  = 1'b1;
                            all_zero_d = all_zero_q & ~vote_c;
                            if (bit_cnt_q == BIT_STOP) break_d = all_zero_q & ~vote_c;
                            else                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            s7_q          <= 1'b1;
            s8_q          <= 1'b1;
            all_zero_q    <= 1'b0;
            tck_arm_q     <= 1'b0;
            rx_o          <= 1'b1;
            tck_o         <= 1'b0;
            busy_o        <= 1'b0;
            false_start_o <= 1'b0;
            noise_o       <= 1'b0;
            break_o       <= 1'b0;
        end else begin
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            s7_q          <= s7_d;
            s8_q          <= s8_d;
            all_zero_q    <= all_zero_d;
            tck_arm_q     <= tck_arm_d;
            rx_o          <= rx_d;
            tck_o         <= tck_d;
            busy_o        <= (state_d != SMP_IDLE);
            false_start_o <= fs_d;
            noise_o       <= noise_d;
            break_o       <= break_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: clean frames, false start, noise, break, back-to-back and mid-frame reset.
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_i = 1'b1;
    logic        enable_i = 1'b1;
    logic [15:0] baud_div_i = 16'd4;
    logic        rx_o, tck_o, busy_o, false_start_o, noise_o, break_o;

    int tests = 0;
    int fails = 0;

    uart_rx_sampler #(.OSR(16), .DIV_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx_i),
        .enable_i      (enable_i),
        .baud_div_i    (baud_div_i),
        .rx_o          (rx_o),
        .tck_o         (tck_o),
        .busy_o        (busy_o),
        .false_start_o (false_start_o),
        .noise_o       (noise_o),
        .break_o       (break_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic tck_prev = 1'b0;
    logic rise_val[$];
    int   rise_t[$];
    int   fs_n = 0;
    int   nz_n = 0;
    int   brk_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record rx_o and time at each tck rise, and count flag pulses
    always @(negedge clk) begin
        tck_prev <= tck_o;
        if (tck_o && !tck_prev) begin
            rise_val.push_back(rx_o);
            rise_t.push_back(cyc);
        end
        if (false_start_o) fs_n  <= fs_n + 1;
        if (noise_o)       nz_n  <= nz_n + 1;
        if (break_o)       brk_n <= brk_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive nbits of a frame; optionally invert one oversample-wide slice around mid-bit of glitch_bit
    task automatic send_frame(input logic [10:0] fr, input int nbits, input int glitch_bit);
        int de;
        de = (baud_div_i == 16'd0) ? 1 : int'(baud_div_i);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 16 * de; c++) begin
                @(negedge clk);
                if (b == glitch_bit && c >= 9 * de && c < 10 * de) rx_i = ~fr[b];
                else                                               rx_i = fr[b];
            end
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [10:0] fr, input int period);
        int bad;
        logic v;
        bad = 0;
        for (int b = 0; b < 11; b++) begin
            v = 1'bx;
            if (base + b < rise_val.size()) v = rise_val[base + b];
            check($sformatf("%s_bit%0d", tag, b), 32'(v), 32'(fr[b]));
        end
        for (int b = 1; b < 11; b++) begin
            if (base + b < rise_t.size()) begin
                if (rise_t[base + b] - rise_t[base + b - 1] != period) bad++;
            end else begin
                bad++;
            end
        end
        check({tag, "_spacing"}, bad, 0);
    endtask

    initial begin
        int base, fs0, nz0, brk0, waited;

        // Reset values
        idle(3);
        check("rst_rx",    32'(rx_o), 1);
        check("rst_tck",   32'(tck_o), 0);
        check("rst_busy",  32'(busy_o), 0);
        check("rst_fs",    32'(false_start_o), 0);
        check("rst_noise", 32'(noise_o), 0);
        check("rst_break", 32'(break_o), 0);
        rst_n = 1'b1;
        idle(50);

        // Clean 0xA5 frame, div 4
        base = rise_val.size(); fs0 = fs_n; nz0 = nz_n; brk0 = brk_n;
        send_frame(mk(8'hA5, 1'b0), 11, -1);
        idle(80);
        check("a5_rises", rise_val.size() - base, 11);
        check_frame("a5", base, 11'b101_0100_1010, 64);
        check("a5_fs",    fs_n - fs0, 0);
        check("a5_noise", nz_n - nz0, 0);
        check("a5_break", brk_n - brk0, 0);
        check("a5_busy",  32'(busy_o), 0);

        // Two-oversample low glitch on idle line
        base = rise_val.size(); fs0 = fs_n;
        repeat (8) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
        @(negedge clk);
        rx_i = 1'b1;
        idle(120);
        check("fs_pulses", fs_n - fs0, 1);
        check("fs_rises",  rise_val.size() - base, 0);
        check("fs_busy",   32'(busy_o), 0);

        // 0x3C with one mid-bit sample of data bit 2 flipped
        base = rise_val.size(); fs0 = fs_n; nz0 = nz_n; brk0 = brk_n;
        send_frame(mk(8'h3C, 1'b0), 11, 3);
        idle(80);
        check("nz_rises", rise_val.size() - base, 11);
        check_frame("nz", base, mk(8'h3C, 1'b0), 64);
        check("nz_noise", nz_n - nz0, 1);
        check("nz_fs",    fs_n - fs0, 0);
        check("nz_break", brk_n - brk0, 0);

        // Line low for 12 bit times
        base = rise_val.size(); brk0 = brk_n;
        repeat (12 * 64) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
        @(negedge clk);
        rx_i = 1'b1;
        idle(1000);
        check("brk_rises_ge11", 32'((rise_val.size() - base) >= 11), 1);
        check_frame("brk", base, 11'b000_0000_0000, 64);
        check("brk_pulses", brk_n - brk0, 1);
        check("brk_busy",   32'(busy_o), 0);

        // Back-to-back 0x00 then 0xFF with divisor 0
        baud_div_i = 16'd0;
        idle(20);
        base = rise_val.size();
        send_frame(mk(8'h00, 1'b0), 11, -1);
        send_frame(mk(8'hFF, 1'b0), 11, -1);
        idle(40);
        check("b2b_rises", rise_val.size() - base, 22);
        check_frame("b2b0", base, mk(8'h00, 1'b0), 16);
        check_frame("b2b1", base + 11, mk(8'hFF, 1'b0), 16);
        check("b2b_gap", (rise_t.size() > base + 11) ? rise_t[base + 11] - rise_t[base + 10] : -1, 16);

        // Reset just after the bit-4 tck rise, then a clean frame
        baud_div_i = 16'd4;
        idle(40);
        base = rise_val.size();
        send_frame(mk(8'hC3, 1'b0), 4, -1);
        rx_i = mk(8'hC3, 1'b0)[4];
        waited = 0;
        while ((rise_val.size() - base) < 5 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_wait_rises", rise_val.size() - base, 5);
        check("pre_rst_tck", 32'(tck_o), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tck",  32'(tck_o), 0);
        check("mid_rst_rx",   32'(rx_o), 1);
        check("mid_rst_busy", 32'(busy_o), 0);
        rx_i = 1'b1;
        idle(5);
        rst_n = 1'b1;
        base = rise_val.size();
        idle(200);
        check("post_rst_no_rise", rise_val.size() - base, 0);
        send_frame(mk(8'h5A, 1'b0), 11, -1);
        idle(80);
        check("post_rst_rises", rise_val.size() - base, 11);
        check_frame("post_rst", base, mk(8'h5A, 1'b0), 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
